// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory stage.
//   size_e  : access size encoding (matches type_control)
//   state_e : memory-stage FSM states
//   RES_*   : write-back result source selects
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // A 32-bit datapath has no double access; it degrades to a word.
    function automatic size_e decode_size(input logic [1:0] tc, input int unsigned data_width);
        if (tc == 2'b11 && data_width == 32)
            return WORD;
        return size_e'(tc);
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/response bus between the memory stage and the data memory.
//   master : memory stage (drives req_*, receives req_ready and rsp_*)
//   slave  : data memory
interface lsu_mem_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the memory stage.
//   st_size_i/st_offset_i/st_data_i : store size, byte offset, right-aligned data
//   st_wdata_o/st_wstrb_o           : lane-shifted store data and byte strobes
//   ld_size_i/ld_offset_i/ld_sign_i : captured load size, offset, sign flag
//   ld_rdata_i                      : raw read data from memory
//   ld_value_o                      : extracted, extended load value
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = 2
) (
    input  size_e                   st_size_i,
    input  logic [OFF_W-1:0]        st_offset_i,
    input  logic [DATA_WIDTH-1:0]   st_data_i,
    output logic [DATA_WIDTH-1:0]   st_wdata_o,
    output logic [DATA_WIDTH/8-1:0] st_wstrb_o,
    input  size_e                   ld_size_i,
    input  logic [OFF_W-1:0]        ld_offset_i,
    input  logic                    ld_sign_i,
    input  logic [DATA_WIDTH-1:0]   ld_rdata_i,
    output logic [DATA_WIDTH-1:0]   ld_value_o
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [DATA_WIDTH-1:0] ld_mask;
    logic                  ld_msb;

    assign st_wdata_o = st_data_i << {st_offset_i, 3'b000};

    always_comb begin
        st_wstrb_o = '0;
        unique case (st_size_i)
            BYTE:    st_wstrb_o = STRB_W'(1)     << st_offset_i;
            HALF:    st_wstrb_o = STRB_W'(2'b11) << st_offset_i;
            WORD:    st_wstrb_o = STRB_W'(4'hF)  << st_offset_i;
            default: st_wstrb_o = '1;
        endcase
    end

    assign ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};

    // Extension is done as mask-and-fill so one expression covers every size
    // without zero-width replications on the 32-bit build.
    always_comb begin
        ld_mask = '1;
        ld_msb  = 1'b0;
        unique case (ld_size_i)
            BYTE: begin
                ld_mask = DATA_WIDTH'(8'hFF);
                ld_msb  = ld_shifted[7];
            end
            HALF: begin
                ld_mask = DATA_WIDTH'(16'hFFFF);
                ld_msb  = ld_shifted[15];
            end
            WORD: begin
                ld_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                ld_msb  = ld_shifted[31];
            end
            default: begin
                ld_mask = '1;
                ld_msb  = 1'b0;
            end
        endcase
        ld_value_o = (ld_shifted & ld_mask) | ((ld_sign_i && ld_msb) ? ~ld_mask : '0);
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// Pipelined load/store memory stage with a handshaked, variable-latency
// data-memory interface.
//   clk, rst              : clock, synchronous active-high reset
//   valid_in, mem_read,
//   mem_write, type_control,
//   sign_ext_flag, result_src,
//   alu_result, write_data, pc4 : instruction fields from EXE/MEM
//   stall                 : hold upstream stages
//   result, result_valid  : write-back value and its qualifier
//   misaligned, bus_error : single-cycle fault pulses
//   mem                   : request/response bus (master side)
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            type_control,
    input  logic                  sign_ext_flag,
    input  logic [1:0]            result_src,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] pc4,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  misaligned,
    output logic                  bus_error,
    lsu_mem_stage_if.master       mem
);
    localparam int NBYTES = int'(bytes_per_word(DATA_WIDTH));
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int STRB_W = NBYTES;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OFF_W-1:0]      off_q, off_d;
    size_e                 size_q, size_d;
    logic                  sign_q, sign_d;
    logic                  we_q, we_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [OFF_W-1:0]      offset;
    size_e                 size_in;
    logic                  misalign_in;
    logic                  timeout_hit;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [STRB_W-1:0]     st_wstrb;
    logic [DATA_WIDTH-1:0] load_value;

    function automatic logic [DATA_WIDTH-1:0] wb_mux(
        input logic [1:0]            src,
        input logic [DATA_WIDTH-1:0] alu,
        input logic [DATA_WIDTH-1:0] pc_plus4,
        input logic [DATA_WIDTH-1:0] mem_val
    );
        unique case (src)
            RES_MEM: return mem_val;
            RES_PC4: return pc_plus4;
            default: return alu;
        endcase
    endfunction

    assign offset       = alu_result[OFF_W-1:0];
    assign size_in      = decode_size(type_control, DATA_WIDTH);
    assign addr_aligned = ADDR_WIDTH'(alu_result) & ~ADDR_WIDTH'(NBYTES - 1);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        misalign_in = 1'b0;
        unique case (size_in)
            HALF:    misalign_in = offset[0];
            WORD:    misalign_in = |offset[1:0];
            DOUBLE:  misalign_in = |offset;
            default: misalign_in = 1'b0;
        endcase
    end

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) u_align (
        .st_size_i   (size_in),
        .st_offset_i (offset),
        .st_data_i   (write_data),
        .st_wdata_o  (st_wdata),
        .st_wstrb_o  (st_wstrb),
        .ld_size_i   (size_q),
        .ld_offset_i (off_q),
        .ld_sign_i   (sign_q),
        .ld_rdata_i  (mem.rsp_rdata),
        .ld_value_o  (load_value)
    );

    assign mem.req_valid = (state_q == REQ) && !rst;
    assign mem.req_we    = (state_q == REQ) && !rst && we_q;
    assign mem.req_addr  = addr_q;
    assign mem.req_wdata = wdata_q;
    assign mem.req_wstrb = wstrb_q;

    // A completing handshake in the same cycle as the timeout wins over the
    // timeout; a load accepted on the timeout cycle is still abandoned.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        sign_d       = sign_q;
        we_d         = we_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        stall        = 1'b0;
        result       = '0;
        result_valid = 1'b0;
        misaligned   = 1'b0;
        bus_error    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (valid_in) begin
                    if (!(mem_read || mem_write)) begin
                        result_valid = 1'b1;
                        result       = wb_mux(result_src, alu_result, pc4, '0);
                    end else if (misalign_in) begin
                        misaligned   = 1'b1;
                        result_valid = 1'b1;
                    end else begin
                        off_d   = offset;
                        size_d  = size_in;
                        sign_d  = sign_ext_flag;
                        we_d    = mem_write;
                        wstrb_d = st_wstrb;
                        wdata_d = st_wdata;
                        addr_d  = addr_aligned;
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.req_ready && we_q) begin
                    result_valid = 1'b1;
                    result       = wb_mux(result_src, alu_result, pc4, '0);
                    state_d      = IDLE;
                end else if (timeout_hit) begin
                    bus_error    = 1'b1;
                    result_valid = 1'b1;
                    state_d      = IDLE;
                end else begin
                    stall = 1'b1;
                    if (mem.req_ready)
                        state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.rsp_valid) begin
                    result_valid = 1'b1;
                    result       = wb_mux(result_src, alu_result, pc4, load_value);
                    state_d      = IDLE;
                end else if (timeout_hit) begin
                    bus_error    = 1'b1;
                    result_valid = 1'b1;
                    state_d      = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            stall        = 1'b0;
            result       = '0;
            result_valid = 1'b0;
            misaligned   = 1'b0;
            bus_error    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= BYTE;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage (32-bit datapath, 8-cycle timeout).
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write, sign_ext_flag;
    logic [1:0]  type_control, result_src;
    logic [31:0] alu_result, write_data, pc4;
    logic        stall, result_valid, misaligned, bus_error;
    logic [31:0] result;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned stall_cycles;
    int unsigned seen;
    int unsigned hit_cycle;

    lsu_mem_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_if ();

    lsu_mem_stage #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .type_control  (type_control),
        .sign_ext_flag (sign_ext_flag),
        .result_src    (result_src),
        .alu_result    (alu_result),
        .write_data    (write_data),
        .pc4           (pc4),
        .stall         (stall),
        .result        (result),
        .result_valid  (result_valid),
        .misaligned    (misaligned),
        .bus_error     (bus_error),
        .mem           (mem_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        valid_in         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        sign_ext_flag    = 1'b0;
        type_control     = 2'b00;
        result_src       = 2'b00;
        alu_result       = '0;
        write_data       = '0;
        pc4              = '0;
        mem_if.req_ready = 1'b0;
        mem_if.rsp_valid = 1'b0;
        mem_if.rsp_rdata = '0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] tc, input logic sx,
                          input logic [1:0] src, input logic [31:0] alu, input logic [31:0] wd);
        valid_in      = 1'b1;
        mem_read      = rd;
        mem_write     = wr;
        type_control  = tc;
        sign_ext_flag = sx;
        result_src    = src;
        alu_result    = alu;
        write_data    = wd;
    endtask

    // Zero-wait load: IDLE, REQ (accepted), RESP with data.
    task automatic load_zero_wait(input string tag, input logic [31:0] alu, input logic [1:0] tc,
                                  input logic sx, input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        clear_inputs();
        set_op(1'b1, 1'b0, tc, sx, 2'b01, alu, 32'h0);
        mem_if.req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = rdata;
        #1;
        check_eq({tag, "_valid"}, 64'(result_valid), 64'd1);
        check_eq({tag, "_result"}, 64'(result), 64'(exp));
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        rst = 1'b1;

        // Reset: outputs quiet even with an instruction presented
        @(negedge clk);
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h55, 32'h0);
        #1;
        check_eq("rst_result_valid", 64'(result_valid), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_req_valid", 64'(mem_if.req_valid), 64'd0);
        check_eq("rst_req_we", 64'(mem_if.req_we), 64'd0);
        check_eq("rst_misaligned", 64'(misaligned), 64'd0);
        check_eq("rst_bus_error", 64'(bus_error), 64'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;

        // Plain ALU op, result_src=11 selects the ALU value
        @(negedge clk);
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 32'h1234, 32'h0);
        #1;
        check_eq("alu_result", 64'(result), 64'h1234);
        check_eq("alu_valid", 64'(result_valid), 64'd1);
        check_eq("alu_stall", 64'(stall), 64'd0);

        // Store byte 0xAB at 0x1003, memory ready immediately
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h1003, 32'hAB);
        mem_if.req_ready = 1'b1;
        #1;
        check_eq("sb_idle_stall", 64'(stall), 64'd1);
        check_eq("sb_idle_req_valid", 64'(mem_if.req_valid), 64'd0);
        @(negedge clk);
        #1;
        check_eq("sb_req_valid", 64'(mem_if.req_valid), 64'd1);
        check_eq("sb_req_we", 64'(mem_if.req_we), 64'd1);
        check_eq("sb_addr", 64'(mem_if.req_addr), 64'h1000);
        check_eq("sb_wstrb", 64'(mem_if.req_wstrb), 64'b1000);
        check_eq("sb_wdata", 64'(mem_if.req_wdata), 64'hAB00_0000);
        check_eq("sb_result_valid", 64'(result_valid), 64'd1);
        check_eq("sb_result", 64'(result), 64'h1003);
        check_eq("sb_stall", 64'(stall), 64'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("sb_after_req_valid", 64'(mem_if.req_valid), 64'd0);
        check_eq("sb_after_valid", 64'(result_valid), 64'd0);

        // Store half at 0x5002 with two cycles of back-pressure
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 32'h5002, 32'hDEAD_1234);
        #1;
        check_eq("sh_idle_stall", 64'(stall), 64'd1);
        @(negedge clk);
        #1;
        check_eq("sh_wait1_req_valid", 64'(mem_if.req_valid), 64'd1);
        check_eq("sh_wait1_stall", 64'(stall), 64'd1);
        check_eq("sh_wait1_valid", 64'(result_valid), 64'd0);
        @(negedge clk);
        #1;
        check_eq("sh_wait2_req_valid", 64'(mem_if.req_valid), 64'd1);
        check_eq("sh_addr", 64'(mem_if.req_addr), 64'h5000);
        check_eq("sh_wdata", 64'(mem_if.req_wdata), 64'h1234_0000);
        check_eq("sh_wstrb", 64'(mem_if.req_wstrb), 64'b1100);
        @(negedge clk);
        mem_if.req_ready = 1'b1;
        #1;
        check_eq("sh_done_valid", 64'(result_valid), 64'd1);
        check_eq("sh_done_stall", 64'(stall), 64'd0);
        @(negedge clk);
        clear_inputs();

        // Load half signed at offset 2, response three cycles after acceptance
        stall_cycles = 0;
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 32'h2002, 32'h0);
        mem_if.req_ready = 1'b1;
        #1;
        if (stall) stall_cycles++;
        @(negedge clk);
        #1;
        if (stall) stall_cycles++;
        check_eq("lh_req_valid", 64'(mem_if.req_valid), 64'd1);
        check_eq("lh_req_we", 64'(mem_if.req_we), 64'd0);
        check_eq("lh_addr", 64'(mem_if.req_addr), 64'h2000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_if.req_ready = 1'b0;
            #1;
            if (stall) stall_cycles++;
            check_eq("lh_wait_valid", 64'(result_valid), 64'd0);
        end
        @(negedge clk);
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = 32'h80FF_1234;
        #1;
        if (stall) stall_cycles++;
        check_eq("lh_result", 64'(result), 64'hFFFF_80FF);
        check_eq("lh_valid", 64'(result_valid), 64'd1);
        check_eq("lh_stall_cycles", 64'(stall_cycles), 64'd4);
        @(negedge clk);
        clear_inputs();

        // Byte loads at offset 1, zero- and sign-extended
        load_zero_wait("lbu", 32'h3001, 2'b00, 1'b0, 32'h0000_F200, 32'h0000_00F2);
        load_zero_wait("lb", 32'h3001, 2'b00, 1'b1, 32'h0000_F200, 32'hFFFF_FFF2);
        load_zero_wait("lw", 32'h3004, 2'b10, 1'b1, 32'h8765_4321, 32'h8765_4321);

        // Misaligned word load: no request, single-cycle flag
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h2002, 32'h0);
        mem_if.req_ready = 1'b1;
        #1;
        check_eq("mis_lw_flag", 64'(misaligned), 64'd1);
        check_eq("mis_lw_valid", 64'(result_valid), 64'd1);
        check_eq("mis_lw_result", 64'(result), 64'h0);
        check_eq("mis_lw_stall", 64'(stall), 64'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_if.req_ready = 1'b1;
            #1;
            if (mem_if.req_valid) seen++;
        end
        check_eq("mis_lw_no_req", 64'(seen), 64'd0);
        check_eq("mis_lw_flag_clear", 64'(misaligned), 64'd0);

        // Misaligned half store at odd address
        @(negedge clk);
        set_op(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 32'h1001, 32'h55);
        #1;
        check_eq("mis_sh_flag", 64'(misaligned), 64'd1);
        check_eq("mis_sh_stall", 64'(stall), 64'd0);
        @(negedge clk);
        clear_inputs();

        // Timeout: load accepted, response withheld
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h4000, 32'h0);
        mem_if.req_ready = 1'b1;
        hit_cycle = 0;
        for (int c = 1; c <= 20 && hit_cycle == 0; c++) begin
            @(negedge clk);
            #1;
            if (bus_error) begin
                hit_cycle = c;
                check_eq("tmo_valid", 64'(result_valid), 64'd1);
                check_eq("tmo_result", 64'(result), 64'h0);
                check_eq("tmo_stall", 64'(stall), 64'd0);
            end
        end
        check_eq("tmo_cycle", 64'(hit_cycle), 64'd8);
        @(negedge clk);
        clear_inputs();
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = 32'h1234_5678;
        #1;
        check_eq("tmo_late_valid", 64'(result_valid), 64'd0);
        check_eq("tmo_late_bus_error", 64'(bus_error), 64'd0);
        check_eq("tmo_late_stall", 64'(stall), 64'd0);
        @(negedge clk);
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h77, 32'h0);
        #1;
        check_eq("tmo_idle_alu", 64'(result), 64'h77);
        check_eq("tmo_idle_stall", 64'(stall), 64'd0);
        @(negedge clk);
        clear_inputs();

        // Reset while waiting in RESP
        @(negedge clk);
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h6000, 32'h0);
        mem_if.req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_if.req_ready = 1'b0;
        #1;
        check_eq("rr_resp_stall", 64'(stall), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rr_stall", 64'(stall), 64'd0);
        check_eq("rr_valid", 64'(result_valid), 64'd0);
        check_eq("rr_req_valid", 64'(mem_if.req_valid), 64'd0);
        check_eq("rr_bus_error", 64'(bus_error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        mem_if.rsp_valid = 1'b1;
        mem_if.rsp_rdata = 32'hFFFF_FFFF;
        #1;
        check_eq("rr_late_valid", 64'(result_valid), 64'd0);
        check_eq("rr_late_stall", 64'(stall), 64'd0);
        check_eq("rr_late_req_valid", 64'(mem_if.req_valid), 64'd0);
        @(negedge clk);
        set_op(1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 32'h99, 32'h0);
        pc4 = 32'h44;
        #1;
        check_eq("rr_pc4_result", 64'(result), 64'h44);
        check_eq("rr_pc4_valid", 64'(result_valid), 64'd1);
        check_eq("rr_pc4_stall", 64'(stall), 64'd0);
        @(negedge clk);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Pipelined load/store memory stage. It replaces the single-cycle data-memory-plus-result-mux stage with a handshaked request/response interface to a variable-latency data memory. It performs byte-lane alignment, write strobes, misalignment detection, load extraction with sign/zero extension, a response timeout, and pipeline stall generation. It sits between the EXE/MEM pipeline register and the MEM/WB register, and drives the write-back result.

Parameters:
DATA_WIDTH, 32, datapath width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 64, cycles allowed in REQ+RESP before a bus error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  instruction present in MEM stage
mem_read  in  1  load
mem_write  in  1  store
type_control  in  2  00 byte, 01 half, 10 word, 11 double (64-bit only; treated as word when DATA_WIDTH=32)
sign_ext_flag  in  1  1 = sign-extend load, 0 = zero-extend
result_src  in  2  00 alu, 01 load, 10 pc4, 11 alu
alu_result  in  DATA_WIDTH  address / ALU value
write_data  in  DATA_WIDTH  store data, right-aligned
pc4  in  DATA_WIDTH  PC+4
stall  out  1  hold upstream stages
result  out  DATA_WIDTH  write-back value
result_valid  out  1  result is valid this cycle
misaligned  out  1  misaligned-access pulse
bus_error  out  1  timeout pulse
req_valid  out  1  memory request valid
req_ready  in  1  memory accepts request
req_we  out  1  request is a write
req_addr  out  ADDR_WIDTH  address, aligned down to a DATA_WIDTH/8 boundary
req_wdata  out  DATA_WIDTH  lane-shifted store data
req_wstrb  out  DATA_WIDTH/8  byte write enables
rsp_valid  in  1  read data valid
rsp_rdata  in  DATA_WIDTH  read data

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- While rst is high or after reset: state=IDLE, timeout counter=0, captured request registers=0, and stall, result_valid, misaligned, bus_error, req_valid, req_we all 0.
- Reset mid-transaction abandons the access. A later rsp_valid is ignored.
- Offset = alu_result[log2(DATA_WIDTH/8)-1:0].
- Misaligned when: half with offset[0]=1; word with offset[1:0]≠0; double with offset≠0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - No memory op (valid_in and neither mem_read nor mem_write): result from mux combinationally; result_valid=valid_in; stall=0; zero added latency.
  - Misaligned memory op: no request issued; misaligned=1; result_valid=1; result=0; stall=0.
  - Aligned memory op: capture offset, size, sign flag, we, strobe and shifted wdata; stall=1; next state REQ.
- REQ:
  - req_valid=1; request fields held stable until accepted.
  - Store accepted on req_valid&req_ready: result_valid=1, result=mux value, stall=0, next IDLE.
  - Load accepted: next RESP; stall=1.
- RESP:
  - stall=1 until rsp_valid.
  - On rsp_valid: extract lane from rsp_rdata>>(8*offset), mask to size, extend per sign flag. result = that value if result_src=01. result_valid=1, stall=0, next IDLE.
- Minimum latency: store 1 extra cycle; load 2 extra cycles (zero-wait memory).
- Upstream holds all inputs stable while stall=1.
- Strobe:
  - byte: 1<<offset.
  - half: 2'b11<<offset.
  - word: 4'hF<<offset.
  - double: all ones.
- Timeout:
  - Counter increments each cycle in REQ or RESP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES-1: bus_error=1, result_valid=1, result=0, stall=0, next IDLE. Any late response is ignored.
- rsp_valid outside RESP is ignored. req_ready outside REQ is ignored.
- valid_in=0 in IDLE: no action; result_valid=0.

Decomposition:
- lsu_pkg holds:
  - size_e (BYTE, HALF, WORD, DOUBLE).
  - state_e (IDLE, REQ, RESP).
  - result_src constants RES_ALU, RES_MEM, RES_PC4.
  - Function for bytes-per-word.
- Sub-module lsu_align, combinational. It handles the store lane shift/strobe generation and the load extraction/extension. The FSM, counter and capture registers stay in lsu_mem_stage.

Test Plan:
- Store byte 0xAB, alu_result=0x1003, req_ready=1 → req_addr=0x1000, req_wstrb=4'b1000, req_wdata=0xAB000000; result_valid after 1 stall cycle.
- Load half signed, offset 2, rsp_rdata=0x80FF1234, 3-cycle response delay → result=0xFFFF80FF, stall high 4 cycles.
- Load byte unsigned, offset 1, rsp_rdata=0x0000F200 → result=0x000000F2.
- Word load at alu_result=0x2002 → misaligned=1, req_valid never asserts, stall=0.
- TIMEOUT_CYCLES=8, load with rsp_valid withheld → bus_error pulse 8 cycles after entering REQ; state back to IDLE; late rsp_valid ignored.
- rst asserted during RESP → all outputs 0 next cycle; following ALU op (result_src=10, pc4=0x44) → result=0x44, result_valid=1, stall=0.
